// File: rtl/rob_inorder_commit_pkg.sv
// rob_pkg: default sizes and entry layout shared by the reorder buffer files
package rob_pkg;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_ADDR_W = 5;
  localparam int ROB_DEPTH  = 8;
  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [ROB_ADDR_W-1:0] addr;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_inorder_commit_ptr.sv
// rob_ptr: wrapping ring pointer with increment and synchronous clear
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/rob_inorder_commit.sv
// rob_inorder_commit: reorder buffer retiring out-of-order results in allocation order
// ROB_FLUSH_EN adds a flush port that discards every entry in one cycle
module rob_inorder_commit
  import rob_pkg::*;
#(
  parameter int DATA_W = ROB_DATA_W,
  parameter int ADDR_W = ROB_ADDR_W,
  parameter int DEPTH = ROB_DEPTH,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  output logic              empty
);
  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t ent [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic fl, alloc_fire, wb_fire, commit_fire;
`ifdef ROB_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  assign alloc_ready  = count != (TAG_W+1)'(DEPTH);
  assign alloc_tag    = tail;
  assign empty        = count == '0;
  assign alloc_fire   = alloc_valid && alloc_ready && !fl;
  assign wb_fire      = wb_valid && ent[wb_tag].valid && !fl;
  assign commit_valid = ent[head].valid && ent[head].ready && !fl;
  assign commit_fire  = commit_valid && commit_ready;
  assign commit_addr  = ent[head].addr;
  assign commit_data  = ent[head].data;
  rob_ptr #(.W(TAG_W)) u_head (.clk, .rst, .clr(fl), .inc(commit_fire), .ptr(head));
  rob_ptr #(.W(TAG_W)) u_tail (.clk, .rst, .clr(fl), .inc(alloc_fire), .ptr(tail));
  // a writeback racing the retirement of the same entry is dropped with it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (fl) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ready <= 1'b0;
      end
    end else begin
      count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
      if (commit_fire) begin
        ent[head].valid <= 1'b0;
        ent[head].ready <= 1'b0;
      end
      if (wb_fire && !(commit_fire && wb_tag == head)) begin
        ent[wb_tag].data  <= wb_data;
        ent[wb_tag].ready <= 1'b1;
      end
      if (alloc_fire) begin
        ent[tail].valid <= 1'b1;
        ent[tail].ready <= 1'b0;
        ent[tail].addr  <= alloc_addr;
      end
    end
endmodule

// File: doc/rob_inorder_commit.md
# rob_inorder_commit

Parametrised reorder buffer between dispatch and register-file writeback. Entries are allocated in program order with a destination register address. Results arrive out of order, tagged by entry index. Entries retire strictly in allocation order through a valid/ready commit port. Compared with the fixed five-entry buffer, this block adds generic depth and width, explicit allocation tags, per-entry ready tracking, a full/empty/count indication, commit backpressure and an optional flush.

## Interface
Parameters:
- DATA_W, 32, width of a result
- ADDR_W, 5, width of the destination register address
- DEPTH, 8, number of entries; power of two, at least 2
- TAG_W, $clog2(DEPTH), derived localparam; not overridable

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_addr  in  ADDR_W  destination register of the new entry
- alloc_ready  out  1  entry available; equals !full
- alloc_tag  out  TAG_W  index the next allocation will receive (tail)
- wb_valid  in  1  result writeback
- wb_tag  in  TAG_W  entry being written
- wb_data  in  DATA_W  result value
- commit_valid  out  1  head entry is ready to retire
- commit_ready  in  1  consumer accepts the head entry
- commit_addr  out  ADDR_W  head destination register
- commit_data  out  DATA_W  head result
- count  out  TAG_W+1  number of occupied entries
- empty  out  1  count == 0
- flush  in  1  discard all entries; present only with ROB_FLUSH_EN

## Operation
- Each entry holds: valid, ready, addr, data. The head and tail pointers are TAG_W bits wide and wrap from DEPTH-1 to 0.
- Allocation fires when alloc_valid && alloc_ready:
  - entry[tail] is set to valid=1, ready=0, addr=alloc_addr
  - tail increments
- Writeback fires when wb_valid && entry[wb_tag].valid:
  - data is set to wb_data and ready is set to 1
  - a writeback to an invalid entry is ignored
  - a repeated writeback to an already-ready entry overwrites data
- commit_valid = entry[head].valid && entry[head].ready, decoded combinationally from registered state. commit_addr and commit_data always show the head entry; they are don't-care when commit_valid is 0.
- Commit fires when commit_valid && commit_ready:
  - entry[head] is cleared (valid=0, ready=0)
  - head increments
- count updates each cycle as +1 on allocation and -1 on commit. A simultaneous allocation and commit leaves count unchanged. full = (count == DEPTH).
- There is no bypass:
  - allocation is refused when full, even if a commit fires in the same cycle
  - a writeback to the head is not visible on commit_valid until the next cycle
  - a writeback in the same cycle as that entry's allocation is ignored
- A commit and a writeback to different tags in the same cycle are both performed.

## Timing
- Reset values of the outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, commit_addr=0, commit_data=0, count=0, empty=1. All entries are cleared and head=tail=0.
- Reset asserts asynchronously and may arrive mid-operation; all in-flight entries are lost. Deassertion is synchronous to clk.
- Minimum latency is 2 cycles from allocation to commit: allocate in cycle 0, write back in cycle 1, commit_valid high in cycle 2.
- Throughput is one allocation, one writeback and one commit per cycle.
- commit_valid is held while commit_ready is low, and commit_addr/commit_data stay stable meanwhile.

## Configuration
- ROB_FLUSH_EN defined: the flush port exists.
  - On a flush cycle all valid and ready bits clear, head=tail=0 and count=0.
  - flush has priority over allocation, writeback and commit in the same cycle; none of them take effect.
  - commit_valid is forced to 0 while flush is high.
  - This is used for branch-mispredict recovery.
- ROB_FLUSH_EN undefined: no flush port and no flush logic; entries leave only by commit or reset.

## Structure
- Package rob_pkg holds:
  - default widths (ROB_DATA_W, ROB_ADDR_W, ROB_DEPTH)
  - the entry typedef rob_entry_t {valid, ready, addr, data}
- Sub-module rob_ptr: a TAG_W-bit wrapping pointer with increment enable, asynchronous active-low reset and clear. It is instantiated for head and tail.

## Test plan
- Reset, then 8 allocations with addr 1..8 (DEPTH=8) → alloc_tags 0..7; after the last, count=8, alloc_ready=0; a ninth alloc_valid is refused and count stays 8.
- Allocate tags 0,1,2; write back tag 2 (0xC), then 1 (0xB), then 0 (0xA), with commit_ready=1 → commits in order addr/data 0xA, 0xB, 0xC on consecutive cycles after tag 0 becomes ready.
- Head ready with commit_ready=0 for 3 cycles → commit_valid held with stable addr/data and count unchanged; raising commit_ready retires the entry in one cycle.
- Run more than 2×DEPTH allocate/writeback/commit operations with simultaneous alloc and commit → tags wrap 7→0, count stays constant, and the commit order matches allocation order.
- Writeback to an unallocated tag 5 → no state change; assert rst low mid-stream → all outputs immediately take their reset values.
- With ROB_FLUSH_EN: 4 entries, 2 ready; assert flush together with alloc_valid and commit_ready → count=0, empty=1, no commit and no allocation; the next allocation gets tag 0.
